// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/owner types and counter width for the 2:1 memory arbiter
package mem_arb_pkg;
  localparam int ARB_CNT_W = 4;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_e;
  typedef enum logic {OWN_IFU, OWN_LSU} arb_owner_e;
endpackage

// File: rtl/mem_arb_grant.sv
// mem_arb_grant: one-hot grant {lsu, ifu}; fixed LSU priority, or round-robin when ARB_RR_EN is defined
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic       i_ifu_valid,
  input  logic       i_lsu_valid,
  input  arb_owner_e i_last_grant,
  output logic [1:0] o_grant
);
  logic w_lsu;
`ifdef ARB_RR_EN
  assign w_lsu = i_lsu_valid & (~i_ifu_valid | (i_last_grant == OWN_IFU));
`else
  logic w_unused_last;
  assign w_unused_last = i_last_grant == OWN_IFU;
  assign w_lsu = i_lsu_valid;
`endif
  assign o_grant = {w_lsu, i_ifu_valid & ~w_lsu};
endmodule

// File: rtl/mem_arb_2to1.sv
// mem_arb_2to1: shares the single RAM port between IFU and LSU, one access at a time.
// Arbitration is fixed LSU-first unless ARB_RR_EN is defined (round-robin).
module mem_arb_2to1
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  input  logic        ifu_resp_ready,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic        lsu_wen,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  input  logic        lsu_resp_ready,
  output logic [31:0] lsu_rdata,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wen,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);
  arb_state_e           r_state, w_state_nxt;
  arb_owner_e           r_owner, r_last, w_owner;
  logic [ARB_CNT_W-1:0] r_cnt;
  logic [31:0]          r_addr, r_wdata, r_rdata;
  logic                 r_wen;
  logic [3:0]           r_wmask;
  logic [1:0]           w_grant;
  logic                 w_idle, w_busy, w_resp, w_accept, w_resp_hs, w_last;

  mem_arb_grant u_grant (
    .i_ifu_valid (ifu_req_valid),
    .i_lsu_valid (lsu_req_valid),
    .i_last_grant(r_last),
    .o_grant     (w_grant)
  );

  // Every state decode is gated by rst so nothing (notably a write) escapes during reset
  assign w_idle    = (r_state == IDLE) && !rst;
  assign w_busy    = (r_state == BUSY) && !rst;
  assign w_resp    = (r_state == RESP) && !rst;
  assign w_last    = r_cnt == '0;
  assign ifu_req_ready = w_idle & w_grant[0];
  assign lsu_req_ready = w_idle & w_grant[1];
  assign w_accept  = ifu_req_ready | lsu_req_ready;
  assign w_owner   = lsu_req_ready ? OWN_LSU : OWN_IFU;
  assign w_resp_hs = w_resp & ((r_owner == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready);

  assign mem_valid = w_busy;
  assign mem_addr  = w_busy ? r_addr : '0;
  assign mem_wdata = w_busy ? r_wdata : '0;
  assign mem_wmask = w_busy ? r_wmask : '0;
  assign mem_wen   = w_busy & w_last & r_wen;

  assign ifu_resp_valid = w_resp & (r_owner == OWN_IFU);
  assign lsu_resp_valid = w_resp & (r_owner == OWN_LSU);
  assign ifu_rdata = ifu_resp_valid ? r_rdata : '0;
  assign lsu_rdata = lsu_resp_valid ? r_rdata : '0;

  always_comb begin
    w_state_nxt = w_accept ? BUSY : (w_busy && w_last) ? RESP : w_resp_hs ? IDLE : r_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= OWN_IFU;
      r_last  <= OWN_LSU;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wen   <= 1'b0;
      r_wmask <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_owner <= w_owner;
        r_last  <= w_owner;
        r_cnt   <= ARB_CNT_W'(MEM_LAT - 1);
        r_addr  <= lsu_req_ready ? lsu_addr : ifu_addr;
        r_wdata <= lsu_req_ready ? lsu_wdata : '0;
        r_wen   <= lsu_req_ready & lsu_wen;
        r_wmask <= lsu_req_ready ? lsu_wmask : '0;
      end else if (w_busy) begin
        if (w_last) r_rdata <= mem_rdata;
        else r_cnt <= r_cnt - ARB_CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_mem_arb_2to1.sv
// tb_mem_arb_2to1: vector table + scoreboard bench for mem_arb_2to1 (MEM_LAT=3),
// with a second MEM_LAT=1 instance for the single-cycle access case.
module tb_mem_arb_2to1;
  localparam int LAT = 3;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, ram_init = 1'b1;
  logic        ifu_req_valid = 0, ifu_req_ready, ifu_resp_valid, ifu_resp_ready = 1;
  logic [31:0] ifu_addr = 0, ifu_rdata;
  logic        lsu_req_valid = 0, lsu_req_ready, lsu_wen = 0, lsu_resp_valid, lsu_resp_ready = 1;
  logic [31:0] lsu_addr = 0, lsu_wdata = 0, lsu_rdata;
  logic [3:0]  lsu_wmask = 0;
  logic        mem_valid, mem_wen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  logic        a_req_valid = 0, a_req_ready, a_resp_valid, a_resp_ready = 1;
  logic [31:0] a_addr = 0, a_rdata, a_lsu_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        a_lsu_req_ready, a_lsu_resp_valid, a_mem_valid, a_mem_wen;
  logic [3:0]  a_mem_wmask;

  mem_arb_2to1 #(.MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_wen(lsu_wen), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  mem_arb_2to1 #(.MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .ifu_req_valid(a_req_valid), .ifu_req_ready(a_req_ready), .ifu_addr(a_addr),
    .ifu_resp_valid(a_resp_valid), .ifu_resp_ready(a_resp_ready), .ifu_rdata(a_rdata),
    .lsu_req_valid(1'b0), .lsu_req_ready(a_lsu_req_ready), .lsu_addr(32'h0),
    .lsu_wdata(32'h0), .lsu_wen(1'b0), .lsu_wmask(4'h0),
    .lsu_resp_valid(a_lsu_resp_valid), .lsu_resp_ready(1'b1), .lsu_rdata(a_lsu_rdata),
    .mem_valid(a_mem_valid), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_wen(a_mem_wen),
    .mem_wmask(a_mem_wmask), .mem_rdata(a_mem_rdata)
  );

  // RAM model: word 0 holds 0x00000413, word i holds {A5, i, 5A5A}
  logic [31:0] ram [0:255];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= (i == 0) ? 32'h0000_0413 : {8'hA5, 8'(i), 16'h5A5A};
    end else if (mem_valid && mem_wen) begin
      for (int b = 0; b < 4; b++) if (mem_wmask[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end
  assign mem_rdata   = ram[mem_addr[9:2]];
  assign a_mem_rdata = ram[a_mem_addr[9:2]];

  int n_chk = 0, n_err = 0;

  task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  task automatic fail(input string n);
    n_chk++;
    n_err++;
    $display("FAIL %s: got timeout/unexpected expected event", n);
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          lsu;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] data;
  } sb_t;
  sb_t sb[$];
  sb_t cur, e;
  int lat = 0, mv_cnt = 0, wen_cnt = 0, wen_at = 0;
  bit prev_rv = 0, ifu_rdy_seen = 0;
  logic [31:0] last_rdata = 0;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      prev_rv = 0;
      lat = 0;
    end else begin
      lat++;
      if (mem_valid) begin
        mv_cnt++;
        check("mem_addr", mem_addr, cur.addr);
        check("mem_wdata", mem_wdata, cur.wdata);
        check("mem_wmask", 32'(mem_wmask), 32'(cur.wmask));
        if (mem_wen) begin
          wen_cnt++;
          wen_at = mv_cnt;
        end
      end
      if ((ifu_resp_valid || lsu_resp_valid) && !prev_rv) begin
        check("resp_latency", 32'(lat), 32'(LAT + 1));
        check("resp_one_owner", 32'(ifu_resp_valid & lsu_resp_valid), 32'h0);
      end
      prev_rv = ifu_resp_valid || lsu_resp_valid;
      if ((ifu_resp_valid && ifu_resp_ready) || (lsu_resp_valid && lsu_resp_ready)) begin
        if (sb.size() == 0) fail("resp_unexpected");
        else begin
          e = sb.pop_front();
          last_rdata = lsu_resp_valid ? lsu_rdata : ifu_rdata;
          check("resp_owner", 32'(lsu_resp_valid), 32'(e.lsu));
          check("resp_rdata", last_rdata, e.data);
          check("mem_valid_cycles", 32'(mv_cnt), 32'(LAT));
          check("mem_wen_cycles", 32'(wen_cnt), 32'(e.wen));
          if (e.wen) check("mem_wen_last", 32'(wen_at), 32'(LAT));
        end
      end
      if (ifu_req_ready) ifu_rdy_seen = 1;
      if ((ifu_req_valid && ifu_req_ready) || (lsu_req_valid && lsu_req_ready)) begin
        cur.lsu   = lsu_req_valid && lsu_req_ready;
        cur.wen   = cur.lsu && lsu_wen;
        cur.addr  = cur.lsu ? lsu_addr : ifu_addr;
        cur.wdata = cur.lsu ? lsu_wdata : 32'h0;
        cur.wmask = cur.lsu ? lsu_wmask : 4'h0;
        cur.data  = ram[cur.addr[9:2]];
        sb.push_back(cur);
        lat = 0;
        mv_cnt = 0;
        wen_cnt = 0;
        wen_at = 0;
      end
    end
  end

  task automatic wait_req(output bit who);
    who = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((ifu_req_valid && ifu_req_ready) || (lsu_req_valid && lsu_req_ready)) begin
        who = lsu_req_valid && lsu_req_ready;
        return;
      end
    end
    fail("req_timeout");
  endtask

  task automatic wait_resp;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((ifu_resp_valid && ifu_resp_ready) || (lsu_resp_valid && lsu_resp_ready)) begin
        cyc;
        return;
      end
    end
    fail("resp_timeout");
    cyc;
  endtask

  task automatic txn(input bit lsu, input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wmask);
    bit who;
    ifu_req_valid = !lsu;
    lsu_req_valid = lsu;
    ifu_addr = addr;
    lsu_addr = addr;
    lsu_wen = wen;
    lsu_wdata = wdata;
    lsu_wmask = wmask;
    wait_req(who);
    check("txn_owner", 32'(who), 32'(lsu));
    cyc;
    ifu_req_valid = 0;
    lsu_req_valid = 0;
    wait_resp;
  endtask

  task automatic do_reset;
    rst = 1;
    ifu_req_valid = 0;
    lsu_req_valid = 0;
    ifu_resp_ready = 1;
    lsu_resp_ready = 1;
    cyc;
    cyc;
    rst = 0;
  endtask

  task automatic check_idle(input string n);
    check({n, "_ctl"}, 32'({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_valid, mem_wen}), 32'h0);
    check({n, "_data"}, mem_addr | mem_wdata | ifu_rdata | lsu_rdata | 32'(mem_wmask), 32'h0);
  endtask

  typedef struct {
    bit          iv;
    bit          lv;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    bit          exp;
  } vec_t;
  vec_t v[7];

  initial begin
    bit who;
    bit exp_b2b[4];
    v[0] = '{1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 1'b0};
    v[1] = '{1'b0, 1'b1, 1'b0, 32'h8000_0004, 32'h0, 4'h0, 1'b1};
    v[2] = '{1'b1, 1'b1, 1'b1, 32'h8000_0008, 32'h1234_5678, 4'hF, !RR};
    v[3] = '{1'b1, 1'b1, 1'b0, 32'h8000_0008, 32'h0, 4'h0, 1'b1};
    v[4] = '{1'b1, 1'b1, 1'b0, 32'h8000_0004, 32'h0, 4'h0, !RR};
    v[5] = '{1'b0, 1'b1, 1'b1, 32'h8000_000C, 32'hCC00_0000, 4'h8, 1'b1};
    v[6] = '{1'b1, 1'b0, 1'b0, 32'h8000_000C, 32'h0, 4'h0, 1'b0};
    exp_b2b = '{!RR, 1'b1, !RR, 1'b1};

    // Reset: requests present while rst is high must not be accepted
    ifu_req_valid = 1;
    lsu_req_valid = 1;
    a_req_valid = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ready_in_reset", 32'({ifu_req_ready, lsu_req_ready, a_req_ready, mem_valid}), 32'h0);
    cyc;
    rst = 0;
    ram_init = 0;
    ifu_req_valid = 0;
    lsu_req_valid = 0;
    a_req_valid = 0;
    @(negedge clk);
    check_idle("reset_outputs");
    cyc;

    // MEM_LAT=1 IFU fetch of 0x80000000
    a_req_valid = 1;
    a_addr = 32'h8000_0000;
    @(negedge clk);
    check("l1_req_ready", 32'(a_req_ready), 32'h1);
    cyc;
    a_req_valid = 0;
    @(negedge clk);
    check("l1_mem_valid_c1", 32'({a_mem_valid, a_resp_valid, a_mem_wen}), 32'b100);
    check("l1_mem_addr", a_mem_addr, 32'h8000_0000);
    cyc;
    @(negedge clk);
    check("l1_mem_valid_c2", 32'({a_mem_valid, a_resp_valid}), 32'b01);
    check("l1_rdata", a_rdata, 32'h0000_0413);
    check("l1_lsu_quiet", 32'({a_lsu_req_ready, a_lsu_resp_valid}) | a_lsu_rdata | a_mem_wdata | 32'(a_mem_wmask), 32'h0);
    cyc;
    @(negedge clk);
    check("l1_resp_done", 32'({a_mem_valid, a_resp_valid}), 32'h0);
    cyc;

    // Partial store then readback of the merged word
    txn(1'b1, 1'b1, 32'h8000_0100, 32'hDEAD_BEEF, 4'b0011);
    txn(1'b0, 1'b0, 32'h8000_0100, 32'h0, 4'h0);
    check("store_readback", last_rdata, 32'hA540_BEEF);

    // Arbitration vector table, starting from reset's last_grant
    do_reset;
    for (int k = 0; k < 7; k++) begin
      ifu_req_valid = v[k].iv;
      lsu_req_valid = v[k].lv;
      ifu_addr = v[k].addr;
      lsu_addr = v[k].addr;
      lsu_wen = v[k].wen;
      lsu_wdata = v[k].wdata;
      lsu_wmask = v[k].wmask;
      wait_req(who);
      check($sformatf("vec%0d_grant", k), 32'(who), 32'(v[k].exp));
      cyc;
      ifu_req_valid = 0;
      lsu_req_valid = 0;
      wait_resp;
    end

    // Both requesters valid every cycle for four accesses
    do_reset;
    ifu_rdy_seen = 0;
    ifu_req_valid = 1;
    lsu_req_valid = 1;
    ifu_addr = 32'h8000_0000;
    lsu_addr = 32'h8000_0004;
    lsu_wen = 0;
    for (int k = 0; k < 4; k++) begin
      wait_req(who);
      check($sformatf("b2b%0d_grant", k), 32'(who), 32'(exp_b2b[k]));
      cyc;
    end
    ifu_req_valid = 0;
    lsu_req_valid = 0;
    wait_resp;
    check("b2b_ifu_ready_seen", 32'(ifu_rdy_seen), 32'(RR));

    // Response back-pressure: LSU response held for 5 cycles
    do_reset;
    lsu_resp_ready = 0;
    lsu_req_valid = 1;
    lsu_wen = 0;
    lsu_addr = 32'h8000_0010;
    wait_req(who);
    cyc;
    lsu_req_valid = 0;
    ifu_req_valid = 1;
    ifu_addr = 32'h8000_0000;
    for (int i = 0; i < 40 && !lsu_resp_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 32'(lsu_resp_valid), 32'h1);
      check("hold_rdata", lsu_rdata, 32'hA504_5A5A);
      check("hold_ready", 32'({ifu_req_ready, lsu_req_ready}), 32'h0);
      cyc;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    lsu_resp_ready = 1;
    @(negedge clk);
    check("ready_at_resp_hs", 32'(ifu_req_ready), 32'h0);
    @(negedge clk);
    check("ready_after_idle", 32'(ifu_req_ready), 32'h1);
    cyc;
    ifu_req_valid = 0;
    wait_resp;

    // Reset in the second BUSY cycle of a store
    do_reset;
    lsu_req_valid = 1;
    lsu_wen = 1;
    lsu_addr = 32'h8000_0020;
    lsu_wdata = 32'hFFFF_FFFF;
    lsu_wmask = 4'hF;
    wait_req(who);
    cyc;
    lsu_req_valid = 0;
    @(negedge clk);
    check("rst_busy1", 32'({mem_valid, mem_wen}), 32'b10);
    cyc;
    rst = 1;
    @(negedge clk);
    check("rst_forced", 32'({mem_valid, mem_wen, lsu_resp_valid}), 32'h0);
    cyc;
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_idle($sformatf("after_rst%0d", i));
    end
    cyc;
    txn(1'b0, 1'b0, 32'h8000_0020, 32'h0, 4'h0);
    check("rst_no_write", last_rdata, 32'hA508_5A5A);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_arb_2to1.md
# mem_arb_2to1

Two-requester arbiter and sequencer that shares the single data port of the unified instruction/data RAM between the instruction fetch unit (IFU) and the load/store unit (LSU). It accepts one request at a time over a valid/ready handshake and drives the RAM's valid/addr/wdata/wen/wmask port for a programmable number of cycles. It captures the read data and returns it to the winning requester over a valid/ready response channel. It sits between the IFU/LSU and the RAM wrapper, and every core memory access goes through it.

## Interface
Parameters:
- MEM_LAT, 1: cycles the RAM port is held active per access; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset: synchronous, active-high.
- ifu_req_valid  in  1  IFU request present.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  32  IFU fetch address.
- ifu_resp_valid  out  1  IFU response valid.
- ifu_resp_ready  in  1  IFU takes the response.
- ifu_rdata  out  32  fetched word.
- lsu_req_valid  in  1  LSU request present.
- lsu_req_ready  out  1  LSU request accepted.
- lsu_addr  in  32  LSU address.
- lsu_wdata  in  32  store data.
- lsu_wen  in  1  1 = store, 0 = load.
- lsu_wmask  in  4  byte-enable mask; bit i enables byte i.
- lsu_resp_valid  out  1  LSU response valid.
- lsu_resp_ready  in  1  LSU takes the response.
- lsu_rdata  out  32  load data; for stores it carries the word read during the access.
- mem_valid  out  1  RAM access active.
- mem_addr  out  32  RAM address.
- mem_wdata  out  32  RAM write data.
- mem_wen  out  1  RAM write enable.
- mem_wmask  out  4  RAM byte mask.
- mem_rdata  in  32  RAM read data; combinational from mem_addr while mem_valid=1.

## Operation
- The FSM has three states: IDLE, BUSY, RESP. Reset forces IDLE, clears the cycle counter and sets last_grant=LSU.
- IDLE:
  - The grant is decided combinationally from the two req_valid inputs (see Configuration).
  - Only the granted requester sees req_ready=1. Both req_ready outputs are 0 in BUSY and RESP.
  - On the req_valid&req_ready handshake, the block latches the owner, addr, wdata, wen and wmask (IFU: wen=0, wmask=0), sets cnt=MEM_LAT-1, updates last_grant and moves to BUSY.
- BUSY:
  - mem_valid=1 and mem_addr/mem_wdata/mem_wmask come from the latched fields.
  - mem_wen equals the latched wen only when cnt==0, so the RAM performs exactly one write per store.
  - When cnt>0, cnt decrements each cycle.
  - When cnt==0, mem_rdata is captured into the response register and the FSM moves to RESP.
- RESP:
  - The owner's resp_valid=1 and its rdata carries the captured word. The other requester's resp_valid=0.
  - While resp_ready=0, resp_valid and rdata stay stable.
  - On resp_ready=1, the FSM moves to IDLE.
- Outside BUSY, mem_valid, mem_wen, mem_wmask and mem_addr are 0, and mem_wdata is 0.
- A requester that keeps req_valid high through BUSY and RESP is not accepted until the next IDLE cycle.
- If rst is asserted in any state, the FSM returns to IDLE at the next edge. Any outstanding transaction is dropped with no response. While rst=1, mem_valid and mem_wen are forced to 0 combinationally, so no partial write occurs.

## Timing
- Reset values: every output is 0. ifu_req_ready and lsu_req_ready may only rise after rst is deasserted.
- Latency:
  - Request handshake at edge E0.
  - mem_valid is high for cycles E0+1 .. E0+MEM_LAT.
  - resp_valid rises in cycle E0+MEM_LAT+1.
- Minimum occupancy is MEM_LAT+2 cycles per access, with one IDLE cycle between back-to-back accesses.
- req_ready depends combinationally on req_valid of both ports. No output depends combinationally on resp_ready.
- If a response handshake and a new req_valid coincide, the new request is only accepted in the following IDLE cycle.

## Configuration
- ARB_RR_EN defined: round-robin arbitration.
  - When both requesters are valid in IDLE, the grant goes to the one that is not last_grant.
  - Because reset sets last_grant=LSU, the IFU wins the first tie after reset.
  - When only one requester is valid, it wins.
- ARB_RR_EN undefined: fixed priority, LSU over IFU. last_grant is still maintained but does not affect the grant.

## Structure
- Package mem_arb_pkg holds:
  - the state enum arb_state_e: IDLE, BUSY, RESP;
  - the owner enum arb_owner_e: OWN_IFU, OWN_LSU;
  - the constant ARB_CNT_W=4.
- One sub-module, mem_arb_grant: the combinational grant logic (two valids plus last_grant in, one-hot grant out), including the ARB_RR_EN variant.
- The FSM, counter, latches and output muxing stay in the top module.

## Test plan
- Reset, then an IFU load of 0x80000000 with the RAM holding 0x00000413 there, MEM_LAT=1: resp_valid at E0+2 with ifu_rdata=0x00000413; mem_valid is high for exactly one cycle.
- LSU store to 0x80000100, wdata 0xDEADBEEF, wmask 4'b0011, MEM_LAT=3: mem_valid is high for 3 cycles, mem_wen is high only in the third, and a later read returns 0x????BEEF with the upper bytes unchanged.
- Both requesters valid every cycle for 4 accesses:
  - with ARB_RR_EN, grants are IFU, LSU, IFU, LSU;
  - without it, all 4 grants go to the LSU and ifu_req_ready stays 0.
- lsu_resp_ready held 0 for 5 cycles: lsu_resp_valid and lsu_rdata stay stable, both req_ready outputs stay 0, and the next grant occurs only after the response handshake plus one IDLE cycle.
- rst asserted in the second BUSY cycle of a MEM_LAT=3 store: mem_wen is never high, there is no resp_valid, all outputs are 0 afterwards, and a fresh request after reset completes normally.
